// File: rtl/panel_host_pkg.sv
// Shared opcodes, response bytes and command-FSM states for the panel host bridge.
// No logic of its own.
// No flow control of its own.
package panel_host_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SYNC  = 2'b10;

    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_SYNC = 8'hA5;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_BUS_RD,
        ST_BUS_WR,
        ST_TX
    } state_t;

endpackage

// File: rtl/panel_resp_ser.sv
// Response serializer: loads a 1- or 4-byte response and emits it MSB first.
// Latency: first byte is valid the cycle after the load.
// Backpressure: each byte is held until tx_ready; o_done flags the edge the last byte goes.
module panel_resp_ser (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld,
    input  logic [31:0] i_ld_word,
    input  logic        i_ld_four,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_done
);

    logic [31:0] r_sh;
    logic [2:0]  r_cnt;
    logic        r_vld;
    logic        w_take;

    assign w_take     = r_vld && i_tx_ready;
    // Combinational so the command FSM can reach IDLE on the same edge.
    assign o_done     = w_take && (r_cnt == 3'd1);
    assign o_tx_data  = r_sh[31:24];
    assign o_tx_valid = r_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (i_ld) begin
            r_sh  <= i_ld_four ? i_ld_word : {i_ld_word[7:0], 24'h0};
            r_cnt <= i_ld_four ? 3'd4 : 3'd1;
            r_vld <= 1'b1;
        end else if (w_take) begin
            r_sh  <= {r_sh[23:0], 8'h0};
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
                r_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/panel_host_bridge.sv
// Byte-stream host to Avalon-MM master for the 32-word front-panel register file.
// Latency: READ strobe 1 cycle after the command byte, response 1 cycle after waitrequest drops.
// Backpressure: rx_ready only in IDLE/WDATA; strobes held through waitrequest; tx held until taken.
module panel_host_bridge
    import panel_host_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [4:0]  o_m_address,
    output logic        o_m_read,
    output logic        o_m_write,
    output logic [31:0] o_m_writedata,
    input  logic [31:0] i_m_readdata,
    input  logic        i_m_waitrequest
);

    state_t      r_state;
    logic [23:0] r_wbuf;
    logic [1:0]  r_bcnt;
    logic [23:0] r_tmo;

    logic        w_rx_fire;
    logic [1:0]  w_op;
    logic        w_ld;
    logic [31:0] w_ld_word;
    logic        w_ld_four;
    logic        w_done;

    assign o_rx_ready = (r_state == ST_IDLE) || (r_state == ST_WDATA);
    assign w_rx_fire  = i_rx_valid && o_rx_ready;
    assign w_op       = i_rx_data[7:6];

    always_comb begin
        w_ld      = 1'b0;
        w_ld_word = {24'h0, RSP_NAK};
        w_ld_four = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire && (w_op != OP_READ) && (w_op != OP_WRITE)) begin
                    w_ld      = 1'b1;
                    w_ld_word = {24'h0, (w_op == OP_SYNC) ? RSP_SYNC : RSP_NAK};
                end
            end
            ST_BUS_RD: begin
                if (!i_m_waitrequest) begin
                    w_ld      = 1'b1;
                    w_ld_word = i_m_readdata;
                    w_ld_four = 1'b1;
                end
            end
            ST_BUS_WR: begin
                if (!i_m_waitrequest) begin
                    w_ld      = 1'b1;
                    w_ld_word = {24'h0, RSP_ACK};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_wbuf        <= '0;
            r_bcnt        <= '0;
            r_tmo         <= '0;
            o_m_address   <= '0;
            o_m_read      <= 1'b0;
            o_m_write     <= 1'b0;
            o_m_writedata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        case (w_op)
                            OP_READ: begin
                                o_m_address <= i_rx_data[4:0];
                                o_m_read    <= 1'b1;
                                r_state     <= ST_BUS_RD;
                            end
                            OP_WRITE: begin
                                o_m_address <= i_rx_data[4:0];
                                r_wbuf      <= '0;
                                r_bcnt      <= '0;
                                r_tmo       <= '0;
                                r_state     <= ST_WDATA;
                            end
                            default: r_state <= ST_TX;
                        endcase
                    end
                end
                ST_WDATA: begin
                    // An accepted byte wins over a timeout expiring on the same edge.
                    if (w_rx_fire) begin
                        r_tmo  <= '0;
                        r_wbuf <= {r_wbuf[15:0], i_rx_data};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            o_m_writedata <= {r_wbuf, i_rx_data};
                            o_m_write     <= 1'b1;
                            r_state       <= ST_BUS_WR;
                        end
                    end else if (r_tmo == TIMEOUT - 24'd1) begin
                        r_tmo   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 24'd1;
                    end
                end
                ST_BUS_RD: begin
                    if (!i_m_waitrequest) begin
                        o_m_read <= 1'b0;
                        r_state  <= ST_TX;
                    end
                end
                ST_BUS_WR: begin
                    if (!i_m_waitrequest) begin
                        o_m_write <= 1'b0;
                        r_state   <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    panel_resp_ser u_ser (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ld       (w_ld),
        .i_ld_word  (w_ld_word),
        .i_ld_four  (w_ld_four),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (w_done)
    );

endmodule

// File: tb/tb_panel_host_bridge.sv
// Scoreboard bench for panel_host_bridge: stimulus pushes expected tx bytes and bus cycles,
// independent monitors pop and compare them.
module tb_panel_host_bridge;

    localparam logic [23:0] TMO = 24'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [4:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'h0;
    logic        m_waitrequest = 1'b0;

    always #5 clk = ~clk;

    panel_host_bridge #(.TIMEOUT(TMO)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .o_rx_ready      (rx_ready),
        .o_tx_data       (tx_data),
        .o_tx_valid      (tx_valid),
        .i_tx_ready      (tx_ready),
        .o_m_address     (m_address),
        .o_m_read        (m_read),
        .o_m_write       (m_write),
        .o_m_writedata   (m_writedata),
        .i_m_readdata    (m_readdata),
        .i_m_waitrequest (m_waitrequest)
    );

    typedef struct packed {
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
    } bus_t;

    int          checks = 0;
    int          errors = 0;
    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] mem_model[32];
    logic [31:0] slave_mem[32];
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    bit          tx_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] val);
        checks++;
        errors++;
        $display("FAIL %s: value %h", name, val);
    endtask

    // Slave and host-side ready models, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!(m_read || m_write)) begin
            m_waitrequest = 1'b0;
            stall_cnt = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
        end else if (stall_cnt > 0) begin
            m_waitrequest = 1'b1;
            stall_cnt--;
        end else begin
            m_waitrequest = 1'b0;
        end
        m_readdata = slave_mem[m_address];
    end

    bit          prev_hold = 1'b0;
    logic [7:0]  prev_tx = 8'h0;
    bit          prev_strobe = 1'b0;
    logic [4:0]  prev_a = '0;
    logic [31:0] prev_d = '0;
    bus_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold   = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'h1);
                chk("tx_hold_data", 32'(tx_data), 32'(prev_tx));
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail("tx_unexpected", 32'(tx_data));
                else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            prev_hold = tx_valid && !tx_ready;
            prev_tx   = tx_data;

            if (m_read && m_write) fail("both_strobes", 32'h3);
            if (prev_strobe && (m_read || m_write)) begin
                chk("addr_stable", 32'(m_address), 32'(prev_a));
                if (m_write) chk("wdata_stable", m_writedata, prev_d);
            end
            prev_strobe = m_read || m_write;
            prev_a      = m_address;
            prev_d      = m_writedata;

            if ((m_read || m_write) && !m_waitrequest) begin
                if (exp_bus.size() == 0) begin
                    fail("bus_unexpected", {26'h0, m_write, m_address});
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("bus_kind", 32'(m_write), 32'(mon_e.wr));
                    chk("bus_addr", 32'(m_address), 32'(mon_e.a));
                    if (mon_e.wr) begin
                        chk("bus_wdata", m_writedata, mon_e.d);
                        slave_mem[m_address] = m_writedata;
                    end
                end
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        if (!ok) fail("rx_accept_timeout", 32'(b));
        rx_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a);
        exp_bus.push_back('{1'b0, a, 32'h0});
        for (int i = 3; i >= 0; i--) exp_tx.push_back(mem_model[a][8*i +: 8]);
        send_byte({2'b00, 1'($urandom_range(0, 1)), a});
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input int gap, input logic b5);
        mem_model[a] = d;
        exp_bus.push_back('{1'b1, a, d});
        exp_tx.push_back(8'h06);
        send_byte({2'b01, b5, a});
        for (int i = 3; i >= 0; i--) begin
            idle(gap);
            send_byte(d[8*i +: 8]);
        end
    endtask

    task automatic do_other(input logic [1:0] op, input logic [5:0] low);
        exp_tx.push_back((op == 2'b10) ? 8'hA5 : 8'h15);
        send_byte({op, low});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || !rx_ready || tx_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) fail("drain_timeout", 32'(exp_tx.size()));
    endtask

    initial begin
        int hi;
        logic [1:0] op;
        for (int i = 0; i < 32; i++) begin
            mem_model[i] = $urandom;
            slave_mem[i] = mem_model[i];
        end
        mem_model[12] = 32'h0001_2345;
        slave_mem[12] = 32'h0001_2345;

        #12;
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_m_read", 32'(m_read), 32'h0);
        chk("rst_m_write", 32'(m_write), 32'h0);
        chk("rst_m_address", 32'(m_address), 32'h0);
        chk("rst_m_writedata", m_writedata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // SYNC: response one cycle after acceptance, no bus cycle.
        exp_tx.push_back(8'hA5);
        send_byte(8'h80);
        chk("sync_lat_valid", 32'(tx_valid), 32'h1);
        chk("sync_lat_data", 32'(tx_data), 32'hA5);
        chk("sync_no_bus", 32'(m_read | m_write), 32'h0);
        drain();

        // WRITE 8'h46 with zero-wait slave: strobe next cycle, ACK the one after.
        do_write(5'd6, 32'h5, 0, 1'b0);
        chk("wr_strobe", 32'(m_write), 32'h1);
        chk("wr_addr", 32'(m_address), 32'h6);
        chk("wr_data", m_writedata, 32'h5);
        idle(1);
        chk("wr_strobe_drop", 32'(m_write), 32'h0);
        chk("wr_ack_valid", 32'(tx_valid), 32'h1);
        chk("wr_ack_data", 32'(tx_data), 32'h06);
        drain();

        // READ 8'h0C with 3 wait cycles and a toggling tx_ready.
        stall_cfg = 3;
        tx_rand   = 1'b1;
        idle(1);
        do_read(5'd12);
        chk("rd_strobe", 32'(m_read), 32'h1);
        hi = 0;
        while (m_read && hi < 50) begin
            hi++;
            idle(1);
        end
        chk("rd_hold_cycles", 32'(hi), 32'h4);
        chk("rd_first_valid", 32'(tx_valid), 32'h1);
        chk("rd_first_data", 32'(tx_data), 32'h00);
        drain();
        stall_cfg = 0;
        tx_rand   = 1'b0;
        idle(1);

        // Reserved opcode, then a normal READ.
        do_other(2'b11, 6'h03);
        chk("nak_valid", 32'(tx_valid), 32'h1);
        drain();
        do_read(5'd5);
        drain();

        // Partial write abandoned after exactly TIMEOUT idle cycles.
        send_byte(8'h50);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(int'(TMO));
        do_other(2'b10, 6'h00);
        drain();

        // Gaps of TIMEOUT-1 idle cycles keep the write alive.
        do_write(5'd3, 32'hDEAD_BEEF, int'(TMO) - 1, 1'b1);
        drain();

        // Reset while the write is stalled on waitrequest.
        stall_cfg = 50;
        idle(1);
        send_byte(8'h41);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        chk("rst_wr_strobe_before", 32'(m_write), 32'h1);
        idle(2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_m_write", 32'(m_write), 32'h0);
        chk("rst_async_tx_valid", 32'(tx_valid), 32'h0);
        stall_cfg = 0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        chk("post_rst_no_tx", 32'(tx_valid), 32'h0);
        do_read(5'd1);
        drain();

        // Randomised traffic with random slave stalls and host backpressure.
        stall_cfg = -1;
        tx_rand   = 1'b1;
        idle(1);
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            case (op)
                2'b00: do_read(5'($urandom_range(0, 31)));
                2'b01: do_write(5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 2)),
                                1'($urandom_range(0, 1)));
                default: do_other(op, 6'($urandom_range(0, 63)));
            endcase
            idle(int'($urandom_range(0, 2)));
        end
        drain();
        tx_rand = 1'b0;
        idle(4);

        chk("end_tx_queue_empty", 32'(exp_tx.size()), 32'h0);
        chk("end_bus_queue_empty", 32'(exp_bus.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        fail("global_timeout", 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/panel_host_bridge.md
# panel_host_bridge

Avalon-MM master that lets a byte-stream host (UART, JTAG FIFO) drive the 32-word front-panel register file on the PDP-6 Avalon bus: key/switch writes, datasw/mas loads, and light readback. Host commands are decoded, each issues one Avalon read or write to the panel slave, and a byte response goes back on a transmit stream. It sits between the host byte FIFOs and the panel slave port.

## Interface
- TIMEOUT, 24'd1000000, idle clocks allowed between write-data bytes before the partial command is discarded
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  host command/data byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host accepts tx_data this cycle
- m_address  out  5  Avalon word address
- m_read  out  1  Avalon read strobe
- m_write  out  1  Avalon write strobe
- m_writedata  out  32  Avalon write data
- m_readdata  in  32  Avalon read data
- m_waitrequest  in  1  Avalon stall

## Operation
- Handshakes: byte transfers when valid & ready on a rising edge; tx_data/tx_valid held stable until taken.
- Command byte: [7:6] opcode, [5] ignored, [4:0] address. Opcodes: 00 READ, 01 WRITE, 10 SYNC, 11 reserved.
- READ: m_address <= addr, m_read held until m_waitrequest low; m_readdata captured that edge; response 4 bytes, MSB first.
- WRITE: collect 4 data bytes MSB first into m_writedata; m_write held until m_waitrequest low; response one byte 8'h06 (ACK).
- SYNC: no bus cycle; response 8'hA5. Reserved: no bus cycle; response 8'h15 (NAK).
- States: IDLE -> (READ) BUS_RD -> TX; IDLE -> (WRITE) WDATA -> BUS_WR -> TX; IDLE -> (SYNC/reserved) TX; TX -> IDLE after last byte taken.
- rx_ready = 1 only in IDLE and WDATA; bytes are never accepted during BUS_RD, BUS_WR, TX.
- WDATA timeout: counter cleared on WDATA entry and on each accepted byte, +1 otherwise; at TIMEOUT go IDLE, discard partial data, no bus cycle, no response.
- m_read and m_write never both 1; m_address/m_writedata stable while strobe asserted.
- Reset values: state IDLE, m_read 0, m_write 0, m_address 0, m_writedata 0, tx_valid 0, tx_data 0, rx_ready 1 (IDLE decode), counters 0.
- Reset mid-operation: strobes drop asynchronously, partial command and pending response lost, no response emitted afterwards.

## Timing
- READ accepted at edge N: m_read high in cycle N+1; with waitrequest 0, data captured at edge N+2 and first tx byte valid in cycle N+2; each additional waitrequest cycle adds one.
- WRITE last data byte accepted at edge N: m_write high cycle N+1; ACK valid cycle N+2 (zero-wait slave).
- SYNC/reserved accepted at edge N: response valid cycle N+1.
- Response bytes: next byte valid the cycle after the previous is taken; with tx_ready held 1, 4-byte read response occupies 4 consecutive cycles.
- Next command byte accepted earliest the cycle after last response byte is taken.
- Timeout fires exactly TIMEOUT cycles after the last accepted byte of a partial write.

## Structure
- Shared package panel_host_pkg: opcode constants (OP_READ, OP_WRITE, OP_SYNC), response constants (RSP_ACK 8'h06, RSP_SYNC 8'hA5, RSP_NAK 8'h15), state enum.
- One sub-module natural: panel_resp_ser, loads 32-bit word plus byte count (1 or 4), shifts bytes MSB first over tx valid/ready, pulses done.
- Command FSM, write-data assembly and timeout counter stay in the top.

## Test plan
- SYNC 8'h80, tx_ready 1 -> tx 8'hA5 one cycle after acceptance, no m_read/m_write.
- WRITE 8'h46, 00 00 00 05 -> m_write one cycle, m_address 5'o06, m_writedata 32'h5; then tx 8'h06.
- READ 8'h0C with m_readdata 32'h0001_2345, m_waitrequest high 3 cycles -> m_read held 4 cycles, tx 00 01 23 45; tx_ready toggled mid-response, bytes unchanged and never duplicated.
- Reserved 8'hC3 -> tx 8'h15, no bus cycle; following READ processed normally.
- WRITE 8'h50 plus 2 bytes, then TIMEOUT=16 idle cycles -> no m_write, no tx; next SYNC returns 8'hA5.
- Reset asserted during BUS_WR with waitrequest high -> m_write 0 immediately, tx_valid 0; after release, READ works and no stale ACK appears.
